// File: rtl/qspi_slave_fifo.sv
// Mode-3 QSPI slave oversampled in clk: write/read/status command decode with byte FIFOs both ways.
// qck/qss/qd_in are synchronised here; the local side sees plain valid/ready byte streams.
module qspi_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [AW:0]   level
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Callers only pop when non-empty and only push when not full or popping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module qspi_slave_fifo #(
  parameter int LANES = 4,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          qck,
  input  logic          qss,
  input  logic [3:0]    qd_in,
  output logic [3:0]    qd_out,
  output logic          qd_oe,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [AW:0]   rx_level,
  output logic [AW:0]   tx_level,
  output logic          rx_overflow,
  output logic          tx_underflow
);
  localparam int NB = 8 / LANES;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, STATUS, IGNORE} state_t;

  state_t         state;
  logic [2:0]     qck_sr, qss_sr;
  logic [LANES-1:0] qd_s1, qd_s2;
  logic [CW-1:0]  bit_cnt, out_cnt;
  logic [7-LANES:0] rx_part;
  logic [7:0]     rx_next, tx_sh, tx_head, load_byte, push_byte;
  logic [3:0]     lvl_sat;
  logic           push_pend, first_stat;
  logic           rise, fall, sel, ss_fall, ss_rise, byte_done;
  logic           out_load, rx_push, rx_pop, rx_drop, tx_push, tx_pop, tx_unf, stat_clr;

  // Plain synchronisers, left out of reset so a reset with qss low never fakes a select edge.
  always_ff @(posedge clk) begin
    qck_sr <= {qck_sr[1:0], qck};
    qss_sr <= {qss_sr[1:0], qss};
    qd_s1  <= qd_in[LANES-1:0];
    qd_s2  <= qd_s1;
  end

  assign rise      = qck_sr[1] & ~qck_sr[2];
  assign fall      = ~qck_sr[1] & qck_sr[2];
  assign sel       = ~qss_sr[1];
  assign ss_fall   = ~qss_sr[1] & qss_sr[2];
  assign ss_rise   = qss_sr[1] & ~qss_sr[2];
  assign rx_next   = {rx_part, qd_s2};
  assign byte_done = rise & sel & (bit_cnt == CW'(NB-1));

  assign rx_valid  = (rx_level != '0);
  assign tx_ready  = (tx_level != (AW+1)'(DEPTH));
  assign rx_pop    = rx_valid & rx_ready;
  assign rx_push   = push_pend & (tx_ready_rx_free() | rx_pop);
  assign rx_drop   = push_pend & ~rx_push;
  assign tx_push   = tx_valid & tx_ready;

  function automatic logic tx_ready_rx_free();
    return rx_level != (AW+1)'(DEPTH);
  endfunction

  assign out_load  = fall & sel & (out_cnt == '0) & ((state == READ) | (state == STATUS));
  assign tx_pop    = out_load & (state == READ) & (tx_level != '0);
  assign tx_unf    = out_load & (state == READ) & (tx_level == '0);
  assign stat_clr  = out_load & (state == STATUS) & first_stat;

  assign lvl_sat   = (int'(rx_level) > 15) ? 4'hF : 4'(rx_level);

  always_comb begin
    load_byte = 8'h00;
    if (state == STATUS)
      load_byte = {rx_overflow, tx_underflow, ~rx_valid, ~tx_ready, lvl_sat};
    else if (tx_level != '0)
      load_byte = tx_head;
  end

  always_comb begin
    qd_out = '0;
    qd_out[LANES-1:0] = tx_sh[7 -: LANES];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      out_cnt      <= '0;
      rx_part      <= '0;
      tx_sh        <= '0;
      qd_oe        <= 1'b0;
      push_pend    <= 1'b0;
      push_byte    <= '0;
      first_stat   <= 1'b0;
      rx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      if (ss_fall) begin
        bit_cnt <= '0;
        out_cnt <= '0;
      end else if (rise && sel) begin
        rx_part <= rx_next[7-LANES:0];
        bit_cnt <= (bit_cnt == CW'(NB-1)) ? '0 : bit_cnt + CW'(1);
      end

      // A set event in the same clk as the status-load clear wins.
      if (stat_clr) begin
        rx_overflow  <= 1'b0;
        tx_underflow <= 1'b0;
      end
      if (rx_drop) rx_overflow  <= 1'b1;
      if (tx_unf)  tx_underflow <= 1'b1;

      case (state)
        IDLE: if (ss_fall) state <= CMD;
        CMD: if (byte_done) begin
          out_cnt <= '0;
          case (rx_next)
            8'h02:   state <= WRITE;
            8'h03:   state <= READ;
            8'h05: begin
              state      <= STATUS;
              first_stat <= 1'b1;
            end
            default: state <= IGNORE;
          endcase
        end
        WRITE: if (byte_done) begin
          push_pend <= 1'b1;
          push_byte <= rx_next;
        end
        READ, STATUS: if (fall && sel) begin
          qd_oe   <= 1'b1;
          tx_sh   <= (out_cnt == '0) ? load_byte : (tx_sh << LANES);
          out_cnt <= (out_cnt == CW'(NB-1)) ? '0 : out_cnt + CW'(1);
          if (out_cnt == '0) first_stat <= 1'b0;
        end
        default: ;
      endcase

      if (ss_rise) begin
        state <= IDLE;
        qd_oe <= 1'b0;
      end
    end
  end

  qspi_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(push_byte),
    .pop(rx_pop), .dout(rx_data), .level(rx_level)
  );

  qspi_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .din(tx_data),
    .pop(tx_pop), .dout(tx_head), .level(tx_level)
  );
endmodule

// File: tb/tb_qspi_slave_fifo.sv
// Drives three slaves (LANES 4, 2, 1) as a QSPI master; rx pops and master reads are scoreboarded.
module tb_qspi_slave_fifo;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       qck_a [3];
  logic       qss_a [3];
  logic [3:0] qd_a [3];
  logic       rx_ready_a [3];
  logic [7:0] tx_data_a [3];
  logic       tx_valid_a [3];
  logic [3:0] qd_out_a [3];
  logic       qd_oe_a [3];
  logic [7:0] rx_data_a [3];
  logic       rx_valid_a [3];
  logic       tx_ready_a [3];
  logic [4:0] rx_level_a [3];
  logic [4:0] tx_level_a [3];
  logic       ovf_a [3];
  logic       unf_a [3];

  int tests = 0;
  int fails = 0;
  logic [7:0] rx_exp [$];
  logic [7:0] rd_exp [$];
  logic [7:0] rd_val;
  event       rd_evt;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 2 : 1;
    logic [3:0] qdo;
    logic       oe, rxv, txr, ovf, unf;
    logic [7:0] rxd;
    logic [4:0] rxl, txl;

    qspi_slave_fifo #(.LANES(L), .DEPTH(16)) u_dut (
      .clk(clk), .rst(rst), .qck(qck_a[g]), .qss(qss_a[g]), .qd_in(qd_a[g]),
      .qd_out(qdo), .qd_oe(oe), .rx_data(rxd), .rx_valid(rxv), .rx_ready(rx_ready_a[g]),
      .tx_data(tx_data_a[g]), .tx_valid(tx_valid_a[g]), .tx_ready(txr),
      .rx_level(rxl), .tx_level(txl), .rx_overflow(ovf), .tx_underflow(unf)
    );

    assign qd_out_a[g]   = qdo;
    assign qd_oe_a[g]    = oe;
    assign rx_data_a[g]  = rxd;
    assign rx_valid_a[g] = rxv;
    assign tx_ready_a[g] = txr;
    assign rx_level_a[g] = rxl;
    assign tx_level_a[g] = txl;
    assign ovf_a[g]      = ovf;
    assign unf_a[g]      = unf;
  end

  function automatic int lanes_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rx_valid_a[k] && rx_ready_a[k]) begin
        if (rx_exp.size() == 0) begin
          tests++; fails++;
          $display("FAIL rx_extra: got %0h expected none", rx_data_a[k]);
        end else begin
          logic [7:0] e;
          e = rx_exp.pop_front();
          chk("rx_data", {24'd0, rx_data_a[k]}, {24'd0, e});
        end
      end
    end
  end

  always @(rd_evt) begin
    if (rd_exp.size() == 0) begin
      tests++; fails++;
      $display("FAIL rd_extra: got %0h expected none", rd_val);
    end else begin
      logic [7:0] e;
      e = rd_exp.pop_front();
      chk("master_rd", {24'd0, rd_val}, {24'd0, e});
    end
  end

  // Mode 3: data changes after the falling edge, both sides sample on the rising edge.
  task automatic spi_byte(input int k, input logic [7:0] wb, input bit rd);
    int l;
    logic [7:0] sh, rb;
    l  = lanes_of(k);
    sh = wb;
    rb = '0;
    for (int b = 0; b < 8 / l; b++) begin
      qck_a[k] = 1'b0;
      qd_a[k]  = '0;
      for (int j = 0; j < l; j++) qd_a[k][j] = sh[8-l+j];
      sh = sh << l;
      wclk(HALF);
      for (int j = 0; j < l; j++) rb = {rb[6:0], qd_out_a[k][l-1-j]};
      if (rd && k != 0) chk("qd_out_hi", {28'd0, qd_out_a[k]} >> l, 0);
      qck_a[k] = 1'b1;
      wclk(HALF);
    end
    if (rd) begin
      rd_val = rb;
      -> rd_evt;
    end
  endtask

  task automatic xfer_start(input int k);
    qss_a[k] = 1'b0;
    wclk(4);
  endtask

  task automatic xfer_end(input int k);
    qss_a[k] = 1'b1;
    wclk(8);
  endtask

  task automatic pop_one(input int k);
    rx_ready_a[k] = 1'b1;
    wclk(1);
    rx_ready_a[k] = 1'b0;
  endtask

  task automatic tx_push(input int k, input logic [7:0] d);
    tx_valid_a[k] = 1'b1;
    tx_data_a[k]  = d;
    wclk(1);
    tx_valid_a[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wclk(4);
    rst = 1'b0;
    wclk(2);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      qck_a[k] = 1'b1; qss_a[k] = 1'b1; qd_a[k] = '0;
      rx_ready_a[k] = 1'b0; tx_data_a[k] = '0; tx_valid_a[k] = 1'b0;
    end
    rst = 1'b1;
    wclk(6);
    rst = 1'b0;
    wclk(2);

    chk("rst_qd_out", {28'd0, qd_out_a[0]}, 0);
    chk("rst_qd_oe", {31'd0, qd_oe_a[0]}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid_a[0]}, 0);
    chk("rst_tx_ready", {31'd0, tx_ready_a[0]}, 1);
    chk("rst_rx_level", {27'd0, rx_level_a[0]}, 0);
    chk("rst_tx_level", {27'd0, tx_level_a[0]}, 0);
    chk("rst_flags", {30'd0, ovf_a[0], unf_a[0]}, 0);

    // Write two bytes, then drain one at a time.
    rx_exp.push_back(8'hA5); rx_exp.push_back(8'h3C);
    xfer_start(0);
    spi_byte(0, 8'h02, 0); spi_byte(0, 8'hA5, 0); spi_byte(0, 8'h3C, 0);
    xfer_end(0);
    chk("t1_level2", {27'd0, rx_level_a[0]}, 2);
    pop_one(0);
    chk("t1_level1", {27'd0, rx_level_a[0]}, 1);
    pop_one(0);
    chk("t1_level0", {27'd0, rx_level_a[0]}, 0);
    chk("t1_flags", {30'd0, ovf_a[0], unf_a[0]}, 0);

    // Read three bytes with only two queued.
    tx_push(0, 8'h11); tx_push(0, 8'h22);
    chk("t2_tx_level", {27'd0, tx_level_a[0]}, 2);
    xfer_start(0);
    spi_byte(0, 8'h03, 0);
    chk("t2_oe_cmd", {31'd0, qd_oe_a[0]}, 0);
    rd_exp.push_back(8'h11); rd_exp.push_back(8'h22); rd_exp.push_back(8'h00);
    spi_byte(0, 8'h00, 1);
    chk("t2_oe_data", {31'd0, qd_oe_a[0]}, 1);
    spi_byte(0, 8'h00, 1); spi_byte(0, 8'h00, 1);
    xfer_end(0);
    chk("t2_oe_desel", {31'd0, qd_oe_a[0]}, 0);
    chk("t2_underflow", {31'd0, unf_a[0]}, 1);
    chk("t2_tx_level0", {27'd0, tx_level_a[0]}, 0);

    // Overfill the rx FIFO, then read the status byte twice.
    do_reset();
    xfer_start(0);
    spi_byte(0, 8'h02, 0);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) rx_exp.push_back(8'h10 + 8'(i));
      spi_byte(0, 8'h10 + 8'(i), 0);
    end
    xfer_end(0);
    chk("t3_level_full", {27'd0, rx_level_a[0]}, 16);
    chk("t3_overflow", {31'd0, ovf_a[0]}, 1);
    rd_exp.push_back(8'h8F); rd_exp.push_back(8'h0F);
    xfer_start(0);
    spi_byte(0, 8'h05, 0); spi_byte(0, 8'h00, 1); spi_byte(0, 8'h00, 1);
    xfer_end(0);
    chk("t3_ovf_cleared", {31'd0, ovf_a[0]}, 0);
    rx_ready_a[0] = 1'b1;
    wclk(20);
    rx_ready_a[0] = 1'b0;
    chk("t3_drained", {27'd0, rx_level_a[0]}, 0);

    // Narrow lane counts: write path and read path.
    for (int k = 1; k < 3; k++) begin
      rx_exp.push_back(8'h81); rx_exp.push_back(8'h7E);
      xfer_start(k);
      spi_byte(k, 8'h02, 0); spi_byte(k, 8'h81, 0); spi_byte(k, 8'h7E, 0);
      xfer_end(k);
      chk("t4_level2", {27'd0, rx_level_a[k]}, 2);
      pop_one(k); pop_one(k);
      chk("t4_level0", {27'd0, rx_level_a[k]}, 0);
      tx_push(k, 8'hC6);
      rd_exp.push_back(8'hC6);
      xfer_start(k);
      spi_byte(k, 8'h03, 0); spi_byte(k, 8'h00, 1);
      xfer_end(k);
      chk("t4_no_unf", {31'd0, unf_a[k]}, 0);
    end

    // Aborted command nibble must not corrupt the next transfer.
    xfer_start(0);
    qck_a[0] = 1'b0; qd_a[0] = 4'h0; wclk(HALF);
    qck_a[0] = 1'b1; wclk(HALF);
    xfer_end(0);
    rx_exp.push_back(8'h55);
    xfer_start(0);
    spi_byte(0, 8'h02, 0); spi_byte(0, 8'h55, 0);
    xfer_end(0);
    chk("t5_level1", {27'd0, rx_level_a[0]}, 1);
    pop_one(0);

    // Reset in the middle of a read.
    tx_push(0, 8'hAA); tx_push(0, 8'hBB); tx_push(0, 8'hCC);
    rd_exp.push_back(8'hAA);
    xfer_start(0);
    spi_byte(0, 8'h03, 0); spi_byte(0, 8'h00, 1);
    qck_a[0] = 1'b0;
    wclk(6);
    chk("t6_oe_before", {31'd0, qd_oe_a[0]}, 1);
    chk("t6_tx_level1", {27'd0, tx_level_a[0]}, 1);
    rst = 1'b1;
    wclk(1);
    chk("t6_oe_after", {31'd0, qd_oe_a[0]}, 0);
    chk("t6_tx_level0", {27'd0, tx_level_a[0]}, 0);
    rst = 1'b0;
    qck_a[0] = 1'b1;
    wclk(HALF);
    xfer_end(0);
    rx_exp.push_back(8'h77);
    xfer_start(0);
    spi_byte(0, 8'h02, 0); spi_byte(0, 8'h77, 0);
    xfer_end(0);
    chk("t6_level1", {27'd0, rx_level_a[0]}, 1);
    pop_one(0);

    wclk(4);
    chk("rx_exp_left", rx_exp.size(), 0);
    chk("rd_exp_left", rd_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
